median_row_loader: RTL
======================

# median_row_loader

Write-side counterpart of the median filter's windowing reader. Accepts a raster pixel stream with a valid/ready handshake and packs four pixels into each 32-bit word. Writes each image row into one of the three input row memories (A, B, C) in rotation, at the word addresses the filter later reads back. Tracks how many complete rows are buffered and back-pressures the stream until the filter releases a row.

## Interface
- PIXEL_DATA_WIDTH, 8, bits per pixel
- MEM_DATA_WIDTH, 32, row-memory word width; equal to 4*PIXEL_DATA_WIDTH
- LUT_ADDR_WIDTH, 10, row-memory address width
- IMG_WIDTH, 320, pixels per row; a multiple of 4; IMG_WIDTH/4 <= 2**LUT_ADDR_WIDTH
- IMG_HEIGHT, 320, rows per frame; >= 3

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- pixel_in  in  PIXEL_DATA_WIDTH  stream pixel, raster order, left to right
- pixel_valid  in  1  pixel_in is valid
- pixel_sof  in  1  marks the first pixel of a frame; qualified by pixel_valid
- pixel_ready  out  1  loader accepts a pixel this cycle
- row_release  in  1  one-cycle pulse from the filter: the oldest buffered row is consumed
- wdata  out  MEM_DATA_WIDTH  packed word
- waddr  out  LUT_ADDR_WIDTH  word column index within the row, 0..IMG_WIDTH/4-1
- we_a, we_b, we_c  out  1 each  write strobes for row memories A, B and C; at most one is high
- rows_valid  out  2  complete rows currently buffered, 0..3
- frame_done  out  1  one-cycle pulse after the last word of the frame is written

## Operation
- A pixel is accepted when pixel_valid and pixel_ready are both high.
- Packing: the first pixel of each 4-pixel group goes in bits [31:24], the second in [23:16], the third in [15:8] and the fourth in [7:0].
  - This matches the reader: xm1 at [31:24] and x2 at [7:0].
- States:
  - IDLE: pixel_ready=1. Accepted pixels without pixel_sof are discarded. An accepted pixel with pixel_sof clears the column, row and rows_valid counters, selects memory A, packs the pixel, and moves to FILL.
  - FILL: pixel_ready=1; pixels are packed.
    - On each 4th pixel, the word is written to waddr = the column word index, on the strobe of the selected memory.
    - On the last word of a row, the selected memory rotates A→B→C→A, the row counter increments, and rows_valid increments.
    - If that was row IMG_HEIGHT-1, go to DONE.
    - Otherwise, if rows_valid becomes 3, go to WAIT_FREE.
  - WAIT_FREE: pixel_ready=0. Return to FILL on the cycle after row_release.
  - DONE: pulse frame_done, then return to IDLE.
- rows_valid:
  - Increments on row completion and decrements on row_release.
  - Both in the same cycle: unchanged.
  - row_release while rows_valid=0: ignored.
  - Holds its value in IDLE; only cleared by sof or rst.
- Mid-frame pixel_sof (in FILL): the partial word is discarded and the frame restarts exactly as from IDLE. Nothing is written for the aborted partial group.
- Arithmetic: the column word counter wraps from IMG_WIDTH/4-1 to 0. The row counter needs clog2(IMG_HEIGHT) bits. No saturation is needed, because the FSM prevents rows_valid from exceeding 3.

## Timing
- Reset values: pixel_ready=0 while rst is asserted and 1 from the first clock after deassertion (IDLE). wdata=0, waddr=0, we_a=we_b=we_c=0, rows_valid=0, frame_done=0.
- Write latency: if the 4th pixel of a group is accepted at edge N, then wdata, waddr and the selected we_x are high during cycle N+1, for exactly one cycle.
- rows_valid updates in the same cycle as the row's last write strobe.
- pixel_ready drops in the cycle after the accept that completed the 3rd buffered row.
- A row_release seen at edge M gives pixel_ready=1 in cycle M+1.
- frame_done is high in the cycle after the last write strobe.
- Throughput: one pixel per clock in FILL.
- rst asserted mid-operation: all state and outputs return to their reset values immediately. No write strobe is emitted for a partial word.

## Configuration
- MEDIAN_LOADER_ERR_EN defined: adds output frame_err (1 bit, reset 0). It is a sticky flag, set on a mid-frame pixel_sof or on pixel_valid held high in WAIT_FREE for more than IMG_WIDTH cycles. It is cleared only by rst or by the next sof accepted in IDLE.
- Not defined: no frame_err port and no detection logic; all other behaviour is identical.

## Test plan
- Reset, then sof plus pixels 0x11,0x22,0x33,0x44 → one cycle later we_a=1, waddr=0, wdata=0x11223344.
- Full 320-pixel row of ramp 0..255 wrapping → 80 strobes on we_a at waddr 0..79, then rows_valid=1; the next row writes on we_b.
- Stream 4 rows with no row_release → pixel_ready=0 after row 3 (rows_valid=3); a single row_release → pixel_ready=1 next cycle, and row 4 writes memory A.
- row_release coincident with a row's last word → rows_valid unchanged; row_release at rows_valid=0 → stays 0.
- Full 320x320 frame with a release after every row → frame_done pulses once, one cycle after the last strobe, then IDLE; non-sof pixels are discarded.
- sof injected at column 6 of row 2 → partial word dropped, next write goes to we_a at waddr 0; frame_err=1 if MEDIAN_LOADER_ERR_EN is defined.

Source files
------------

// File: rtl/median_row_loader.sv
// Purpose: packs a raster pixel stream 4 pixels per word and writes each row into row memory A/B/C in rotation.
// Latency: wdata/waddr/we_x are valid for one cycle, the cycle after the 4th pixel of a group is accepted.
// Backpressure: pixel_ready drops once 3 complete rows are buffered and returns the cycle after row_release.
// Optional feature: define MEDIAN_LOADER_ERR_EN to add the sticky frame_err output.
module median_row_loader #(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int MEM_DATA_WIDTH   = 32,
    parameter int LUT_ADDR_WIDTH   = 10,
    parameter int IMG_WIDTH        = 320,
    parameter int IMG_HEIGHT       = 320
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel_in,
    input  logic                        pixel_valid,
    input  logic                        pixel_sof,
    output logic                        pixel_ready,
    input  logic                        row_release,
    output logic [MEM_DATA_WIDTH-1:0]   wdata,
    output logic [LUT_ADDR_WIDTH-1:0]   waddr,
    output logic                        we_a,
    output logic                        we_b,
    output logic                        we_c,
    output logic [1:0]                  rows_valid,
    output logic                        frame_done
`ifdef MEDIAN_LOADER_ERR_EN
    ,
    output logic                        frame_err
`endif
);

    localparam int WORDS_PER_ROW = IMG_WIDTH / 4;
    localparam int ROW_W         = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PACK_W        = 3 * PIXEL_DATA_WIDTH;
    localparam logic [LUT_ADDR_WIDTH-1:0] LAST_COL = LUT_ADDR_WIDTH'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]          LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT_FREE, S_DONE} state_t;
    typedef enum logic [1:0] {MEM_A, MEM_B, MEM_C} mem_sel_t;

    state_t                    state_q;
    state_t                    state_d;
    mem_sel_t                  sel_q;
    logic [1:0]                grp_q;
    logic [PACK_W-1:0]         pack_q;
    logic [LUT_ADDR_WIDTH-1:0] col_q;
    logic [ROW_W-1:0]          row_q;

    logic       accept;
    logic       sof_acc;
    logic       pix_acc;
    logic       word_done;
    logic       row_done;
    logic       last_row;
    logic       rel_eff;
    logic [1:0] rows_d;
    logic       ready_d;
    logic       done_d;

    // Handshake qualification, word/row completion events and next buffered-row count
    always_comb begin
        accept    = pixel_valid & pixel_ready;
        sof_acc   = accept & pixel_sof;
        pix_acc   = accept & ~pixel_sof & (state_q == S_FILL);
        word_done = pix_acc & (grp_q == 2'd3);
        row_done  = word_done & (col_q == LAST_COL);
        last_row  = row_done & (row_q == LAST_ROW);
        rel_eff   = row_release & (rows_valid != 2'd0);
        if (sof_acc) begin
            rows_d = 2'd0;
        end else if (row_done && !rel_eff) begin
            rows_d = rows_valid + 2'd1;
        end else if (!row_done && rel_eff) begin
            rows_d = rows_valid - 2'd1;
        end else begin
            rows_d = rows_valid;
        end
    end

    // State register plus the registered handshake and frame_done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pixel_ready <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_ready <= ready_d;
            frame_done  <= done_d;
        end
    end

    // Next-state logic: a frame restart wins, then end of frame, then the 3-row limit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sof_acc) state_d = S_FILL;
            end
            S_FILL: begin
                if (sof_acc) begin
                    state_d = S_FILL;
                end else if (last_row) begin
                    state_d = S_DONE;
                end else if (row_done && (rows_d == 2'd3)) begin
                    state_d = S_WAIT_FREE;
                end
            end
            S_WAIT_FREE: begin
                if (row_release) state_d = S_FILL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: ready follows the state being entered; frame_done trails the DONE cycle
    always_comb begin
        ready_d = (state_d == S_IDLE) || (state_d == S_FILL);
        done_d  = (state_q == S_DONE);
    end

    // Pixel packing, word writes, memory rotation and buffered-row count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q      <= 2'd0;
            pack_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            sel_q      <= MEM_A;
            wdata      <= '0;
            waddr      <= '0;
            we_a       <= 1'b0;
            we_b       <= 1'b0;
            we_c       <= 1'b0;
            rows_valid <= 2'd0;
        end else begin
            we_a       <= 1'b0;
            we_b       <= 1'b0;
            we_c       <= 1'b0;
            rows_valid <= rows_d;
            if (sof_acc) begin
                // The sof pixel opens a fresh group; any partial word is simply dropped
                pack_q <= {pack_q[PACK_W-PIXEL_DATA_WIDTH-1:0], pixel_in};
                grp_q  <= 2'd1;
                col_q  <= '0;
                row_q  <= '0;
                sel_q  <= MEM_A;
            end else if (pix_acc) begin
                pack_q <= {pack_q[PACK_W-PIXEL_DATA_WIDTH-1:0], pixel_in};
                grp_q  <= grp_q + 2'd1;
                if (word_done) begin
                    // Oldest pixel lands in the top byte
                    wdata <= {pack_q, pixel_in};
                    waddr <= col_q;
                    we_a  <= (sel_q == MEM_A);
                    we_b  <= (sel_q == MEM_B);
                    we_c  <= (sel_q == MEM_C);
                    if (row_done) begin
                        col_q <= '0;
                        row_q <= row_q + ROW_W'(1);
                        case (sel_q)
                            MEM_A:   sel_q <= MEM_B;
                            MEM_B:   sel_q <= MEM_C;
                            default: sel_q <= MEM_A;
                        endcase
                    end else begin
                        col_q <= col_q + LUT_ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

`ifdef MEDIAN_LOADER_ERR_EN
    localparam int WCNT_W = $clog2(IMG_WIDTH + 1);

    logic [WCNT_W-1:0] wait_cnt_q;

    // Sticky error: restart mid-frame, or a source stalled too long while rows are full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            frame_err  <= 1'b0;
        end else begin
            if ((state_q == S_WAIT_FREE) && pixel_valid) begin
                if (wait_cnt_q != WCNT_W'(IMG_WIDTH)) wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
            end else begin
                wait_cnt_q <= '0;
            end
            if ((state_q == S_IDLE) && sof_acc) begin
                frame_err <= 1'b0;
            end else if (((state_q == S_FILL) && sof_acc) ||
                         ((state_q == S_WAIT_FREE) && pixel_valid &&
                          (wait_cnt_q == WCNT_W'(IMG_WIDTH)))) begin
                frame_err <= 1'b1;
            end
        end
    end
`endif

endmodule
